// File: rtl/traffic_pkg.sv
// Shared constants for the traffic light controller: lamp codes, state encoding, mode polarity.
// Defining TRAFFIC_ALL_RED_EN adds the all-red clearance states and widens the state index.
package traffic_pkg;

`ifdef TRAFFIC_ALL_RED_EN
   localparam int ST_W = 3;
`else
   localparam int ST_W = 2;
`endif

   localparam logic [1:0] LAMP_GREEN  = 2'b00;
   localparam logic [1:0] LAMP_YELLOW = 2'b01;
   localparam logic [1:0] LAMP_RED    = 2'b10;

   localparam logic MODE_PARADE = 1'b1;

`ifdef TRAFFIC_ALL_RED_EN
   typedef enum logic [ST_W-1:0] {
      S0  = 3'd0,
      S1  = 3'd1,
      S2  = 3'd2,
      S3  = 3'd3,
      S1R = 3'd4,
      S3R = 3'd5
   } state_t;
`else
   typedef enum logic [ST_W-1:0] {
      S0 = 2'd0,
      S1 = 2'd1,
      S2 = 2'd2,
      S3 = 2'd3
   } state_t;
`endif

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/phase_timer.sv
// Saturating up-counter measuring how long the controller has spent in its current phase.
module phase_timer #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         srst,
   input  logic         clr,
   output logic [W-1:0] count
);

   // Saturation keeps long waits from wrapping back under the exit thresholds.
   always_ff @(posedge clk) begin
      if (srst || clr) begin
         count <= '0;
      end else if (count != {W{1'b1}}) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/traffic_light_ctrl.sv
// Two-street lights sequencer (A = Academic, B = Bravo); parade mode holds B green.
// Optional macro TRAFFIC_ALL_RED_EN inserts all-red clearance after each yellow.
module traffic_light_ctrl
   import traffic_pkg::*;
#(
   parameter int YELLOW_CYC    = 3,
   parameter int MIN_GREEN_CYC = 4,
   parameter int ALLRED_CYC    = 2
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_m,
   input  logic            i_ta,
   input  logic            i_tb,
   output logic [1:0]      o_la,
   output logic [1:0]      o_lb,
   output logic [ST_W-1:0] o_st
);

   localparam int TW = $clog2(max3(YELLOW_CYC, MIN_GREEN_CYC, ALLRED_CYC) + 1);

   localparam logic [TW-1:0] Y_LAST = TW'(YELLOW_CYC - 1);
   localparam logic [TW-1:0] G_LAST = TW'(MIN_GREEN_CYC - 1);
`ifdef TRAFFIC_ALL_RED_EN
   localparam logic [TW-1:0] R_LAST = TW'(ALLRED_CYC - 1);
`endif

   state_t          state_reg;
   state_t          state_next;
   logic [TW-1:0]   timer;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_reg <= S0;
      end else begin
         state_reg <= state_next;
      end
   end

   // The timer restarts on every phase change so each phase measures its own age.
   phase_timer #(
      .W (TW)
   ) u_phase_timer (
      .clk   (i_clk),
      .srst  (i_rst),
      .clr   (state_next != state_reg),
      .count (timer)
   );

   always_comb begin
      state_next = state_reg;
      o_la       = LAMP_RED;
      o_lb       = LAMP_RED;
      o_st       = state_reg;
      case (state_reg)
         S0: begin
            o_la = LAMP_GREEN;
            if (timer >= G_LAST && !i_ta) begin
               state_next = S1;
            end
         end
         S1: begin
            o_la = LAMP_YELLOW;
            if (timer == Y_LAST) begin
`ifdef TRAFFIC_ALL_RED_EN
               state_next = S1R;
`else
               state_next = S2;
`endif
            end
         end
         S2: begin
            o_lb = LAMP_GREEN;
            if (i_m != MODE_PARADE && timer >= G_LAST && !i_tb) begin
               state_next = S3;
            end
         end
         S3: begin
            o_lb = LAMP_YELLOW;
            if (timer == Y_LAST) begin
`ifdef TRAFFIC_ALL_RED_EN
               state_next = S3R;
`else
               state_next = S0;
`endif
            end
         end
`ifdef TRAFFIC_ALL_RED_EN
         S1R: begin
            if (timer == R_LAST) begin
               state_next = S2;
            end
         end
         S3R: begin
            if (timer == R_LAST) begin
               state_next = S0;
            end
         end
`endif
         default: begin
            // Unused encodings fall back to a known phase with both lamps red.
            state_next = S0;
         end
      endcase
   end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Scoreboard bench for traffic_light_ctrl: directed per-cycle stimulus, decoupled monitor.
module tb_traffic_light_ctrl;

`ifdef TRAFFIC_ALL_RED_EN
   localparam int STW = 3;
`else
   localparam int STW = 2;
`endif

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           m   = 1'b0;
   logic           ta  = 1'b0;
   logic           tb  = 1'b0;
   logic [1:0]     la;
   logic [1:0]     lb;
   logic [STW-1:0] st;

   typedef struct {
      int st;
      int idx;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   passed = 0;
   int   nsteps = 0;

   always #5 clk = ~clk;

   traffic_light_ctrl dut (
      .i_clk (clk),
      .i_rst (rst),
      .i_m   (m),
      .i_ta  (ta),
      .i_tb  (tb),
      .o_la  (la),
      .o_lb  (lb),
      .o_st  (st)
   );

   function automatic int exp_la(input int s);
      return (s == 0) ? 0 : (s == 1) ? 1 : 2;
   endfunction

   function automatic int exp_lb(input int s);
      return (s == 2) ? 0 : (s == 3) ? 1 : 2;
   endfunction

   task automatic check(input string name, input int idx, input int act, input int exp);
      checks++;
      if (act == exp) passed++;
      else $display("FAIL %s step %0d: got %0d, expected %0d", name, idx, act, exp);
   endtask

   // One cycle of stimulus; est is the state expected after the next rising edge.
   task automatic step(input logic r, input logic im, input logic ita, input logic itb,
                       input int est);
      @(negedge clk);
      rst = r; m = im; ta = ita; tb = itb;
      sb.push_back('{est, nsteps});
      nsteps++;
   endtask

   // Remainder of A yellow after its entry edge, ending on the edge into S2.
   task automatic a_yellow_rest(input logic im, input logic ita, input logic itb);
      step(0, im, ita, itb, 1);
      step(0, im, ita, itb, 1);
`ifdef TRAFFIC_ALL_RED_EN
      step(0, im, ita, itb, 4);
      step(0, im, ita, itb, 4);
`endif
      step(0, im, ita, itb, 2);
   endtask

   // Remainder of B yellow after its entry edge, ending on the edge into S0.
   task automatic b_yellow_rest(input logic im, input logic ita, input logic itb);
      step(0, im, ita, itb, 3);
      step(0, im, ita, itb, 3);
`ifdef TRAFFIC_ALL_RED_EN
      step(0, im, ita, itb, 5);
      step(0, im, ita, itb, 5);
`endif
      step(0, im, ita, itb, 0);
   endtask

   // Monitor: the Moore outputs are presented every cycle, sampled 1 time unit after the edge.
   always begin
      exp_t e;
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         $display("step %0d: st=%0d la=%0d lb=%0d (exp st=%0d)", e.idx, st, la, lb, e.st);
         check("st", e.idx, int'(st), e.st);
         check("la", e.idx, int'(la), exp_la(e.st));
         check("lb", e.idx, int'(lb), exp_lb(e.st));
         checks++;
         if (la == 2'b10 || lb == 2'b10) passed++;
         else $display("FAIL safety step %0d: la=%0d lb=%0d, required one lamp red", e.idx, la, lb);
      end
   end

   initial begin
      // Reset with random inputs.
      repeat (3) step(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 0);
      // A traffic holds S0; parade bit ignored here.
      repeat (10) step(0, 1, 1, 0, 0);
      step(0, 0, 0, 0, 1);
      a_yellow_rest(0, 1, 1);
      // Parade holds B green regardless of timer and sensor.
      repeat (20) step(0, 1, 0, 0, 2);
      // Mode falls after min green with no B traffic: exits on that edge.
      step(0, 0, 0, 0, 3);
      // Mode rising during B yellow has no effect.
      b_yellow_rest(1, 0, 0);
      // Minimum green on A with no traffic: exactly 4 cycles.
      repeat (3) step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1);
      a_yellow_rest(0, 0, 1);
      // B traffic keeps S2 beyond min green.
      repeat (6) step(0, 0, 0, 1, 2);
      step(0, 0, 0, 0, 3);
      b_yellow_rest(0, 1, 0);
      // Back to S2, then minimum green on B with no traffic.
      repeat (3) step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1);
      a_yellow_rest(0, 0, 0);
      repeat (3) step(0, 0, 0, 0, 2);
      step(0, 0, 0, 0, 3);
      b_yellow_rest(0, 0, 0);
      // Reset mid-S2 returns to S0 with a fresh timer.
      repeat (3) step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1);
      a_yellow_rest(0, 0, 0);
      step(0, 0, 0, 1, 2);
      step(1, 0, 0, 1, 0);
      repeat (3) step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1);

      repeat (2) @(negedge clk);
      checks++;
      if (sb.size() == 0) passed++;
      else $display("FAIL drain: %0d entries left, expected 0", sb.size());
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete, expected finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/traffic_light_ctrl.md
Name: traffic_light_ctrl

Overview:
Lights-sequencing FSM for a two-street intersection (Academic = street A, Bravo = street B). Consumes the mode bit from the upstream mode FSM (1 = parade, 0 = normal) and the per-street traffic sensors. Drives the A and B lamp codes. In parade mode, Bravo is held green. Yellow durations and minimum green durations are enforced by an internal phase timer.

Parameters:
YELLOW_CYC, 3, exact number of cycles each yellow phase lasts (must be >= 1)
MIN_GREEN_CYC, 4, minimum cycles a green phase lasts before it may end (must be >= 1)
ALLRED_CYC, 2, cycles of all-red clearance; used only when ALL_RED_EN is defined (must be >= 1)

Ports:
i_clk  input  1  rising-edge clock
i_rst  input  1  synchronous reset, active-high
i_m    input  1  mode from upstream mode FSM (registered there); 1 = parade
i_ta   input  1  traffic present on Academic
i_tb   input  1  traffic present on Bravo
o_la   output 2  Academic lamp code: 00 green, 01 yellow, 10 red
o_lb   output 2  Bravo lamp code, same encoding
o_st   output 2  current state index (debug/verification visibility)

Behaviour:
- Reset: synchronous, active-high, sampled on the rising edge of i_clk; takes priority over all other inputs. Reset value of state is S0 (o_la=00, o_lb=10, o_st=0); timer = 0.
- Reset asserted mid-phase: on the next edge, return to S0 with timer 0, whatever the current state.
- Moore machine: o_la, o_lb and o_st are decoded only from the state register, with no input-to-output paths. Outputs change on the same edge as the state.
- Phase timer: cleared to 0 on every edge where the state changes. Otherwise increments by 1 per cycle and saturates at its maximum; it never wraps. Width is $clog2 of max(YELLOW_CYC, MIN_GREEN_CYC, ALLRED_CYC)+1.
- S0 (A green, B red):
  - go to S1 when timer >= MIN_GREEN_CYC-1 and i_ta == 0;
  - otherwise stay.
  - i_m is ignored in S0.
- S1 (A yellow, B red): go to S2 when timer == YELLOW_CYC-1, so S1 lasts exactly YELLOW_CYC cycles. Inputs are ignored.
- S2 (A red, B green):
  - if i_m == 1, stay; parade holds B green indefinitely, regardless of the timer and i_tb;
  - else go to S3 when timer >= MIN_GREEN_CYC-1 and i_tb == 0;
  - otherwise stay.
- S3 (A red, B yellow): go to S0 when timer == YELLOW_CYC-1. Inputs are ignored.
- Simultaneous events:
  - i_m rising while in S3: no effect; yellow completes and the FSM enters S0.
  - i_m falling in S2 after minimum green has elapsed, with i_tb == 0: S2 exits on that same edge.
- Never both lamps non-red in the same cycle; no direct green-to-green transitions.
- No unreachable-state lockup: any illegal state encoding recovers to S0 on the next edge.

Optional Feature:
Macro TRAFFIC_ALL_RED_EN.
- Defined: adds states S1R (after S1) and S3R (after S3), both with o_la=10 and o_lb=10. Each lasts exactly ALLRED_CYC cycles and then enters S2 or S0 respectively. o_st widens to 3 bits; S1R=4, S3R=5.
- Undefined: those states, the ALLRED_CYC logic and the extra o_st bit are absent; yellow goes directly to the opposing green.

Decomposition:
- Shared package traffic_pkg holds:
  - lamp code constants LAMP_GREEN, LAMP_YELLOW, LAMP_RED;
  - state encoding constants S0..S3 (plus S1R/S3R);
  - the mode polarity constant MODE_PARADE = 1.
- One sub-module, phase_timer: saturating up-counter with synchronous clear and a parameterised width. It is instantiated once; the FSM compares its count against the parameters.

Test Plan:
- Reset held 3 cycles with random inputs -> o_la=00, o_lb=10, o_st=0 on each cycle; timer at 0 after release.
- i_ta=1 for 10 cycles, then 0 -> S0 held while i_ta=1; S1 entered on the first edge with i_ta=0; o_la=01 for exactly 3 cycles; then S2 (o_la=10, o_lb=00).
- From S0 entry, i_ta=0 throughout -> S0 lasts exactly 4 cycles (minimum green), then S1 for 3 cycles, then S2.
- In S2 assert i_m=1 for 20 cycles with i_tb=0 -> B stays green throughout. Deassert i_m after 20 cycles -> S3 on the next edge, o_lb=01 for 3 cycles, then S0.
- Assert i_m during S3 -> S3 still completes in 3 cycles and enters S0. Then assert i_rst during S2 -> S0 on the next edge.
- With TRAFFIC_ALL_RED_EN defined -> after each yellow, both lamps are 10 for exactly 2 cycles (o_st=4 or 5) before the opposing green. Checker confirms that no cycle ever has both lamps non-red.
